// File: rtl/mac_rxbuf_if.sv
// Bus bundle for mac_rxbuf: byte-wide MAC receive stream in, 32-bit AXI-Stream out.
// The slave modport is the buffer's view; master is the MAC/sink environment's view.
interface mac_rxbuf_if;
  logic [7:0]  mac_rx_data;
  logic        mac_rx_valid;
  logic        mac_rx_sof;
  logic        mac_rx_eof;
  logic        mac_rx_err;
  logic        axis_tready;
  logic [31:0] axis_tdata;
  logic [3:0]  axis_tkeep;
  logic        axis_tvalid;
  logic        axis_tlast;

  modport master (
    output mac_rx_data, mac_rx_valid, mac_rx_sof, mac_rx_eof, mac_rx_err, axis_tready,
    input  axis_tdata, axis_tkeep, axis_tvalid, axis_tlast
  );

  modport slave (
    input  mac_rx_data, mac_rx_valid, mac_rx_sof, mac_rx_eof, mac_rx_err, axis_tready,
    output axis_tdata, axis_tkeep, axis_tvalid, axis_tlast
  );
endinterface

// File: rtl/mac_rxbuf.sv
// Store-and-forward MAC receive buffer: packs bytes little-endian into 32-bit words,
// commits a frame only when it ends clean, and discards errored/aborted/overflowing frames.
module mac_rxbuf #(
  parameter int FIFO_AW = 9,
  parameter bit SIM     = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  mac_rxbuf_if.slave  bus,
  output logic        frame_drop,
  output logic [15:0] drop_cnt
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic {S_IDLE, S_RXD} state_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } entry_t;

  entry_t           r_mem [DEPTH];
  state_t           r_state, w_state_nxt;
  logic [7:0]       r_in_data;
  logic             r_in_vld, r_in_sof, r_in_eof, r_in_err;
  logic [1:0]       r_bcnt, w_bcnt_nxt, w_lane;
  logic             r_bad, w_bad_nxt, w_bad_now;
  logic [23:0]      r_acc, w_acc_nxt;
  logic [FIFO_AW:0] r_wr_ptr, r_wr_cmt, r_rd_ptr;
  logic [FIFO_AW:0] w_wr_ptr_nxt, w_wr_cmt_nxt, w_base;
  logic             w_start, w_abort, w_accept, w_full, w_wr_word, w_mem_we, w_eof_bad;
  entry_t           w_wentry;
  logic             r_frame_drop;
  logic [15:0]      r_drop_cnt;
  logic [16:0]      w_drop_sum;
  entry_t           r_pf, r_out;
  logic             r_pf_vld, r_out_vld, w_out_load, w_rd_en;

  // Input byte is registered first; the framing logic works on the registered copy.
  // NOTE: every clocked state element uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_in_vld  <= 1'b0;
      r_in_data <= '0;
      r_in_sof  <= 1'b0;
      r_in_eof  <= 1'b0;
      r_in_err  <= 1'b0;
    end else begin
      r_in_vld  <= bus.mac_rx_valid;
      r_in_data <= bus.mac_rx_data;
      r_in_sof  <= bus.mac_rx_sof;
      r_in_eof  <= bus.mac_rx_eof;
      r_in_err  <= bus.mac_rx_err;
    end
  end

  // A sof byte restarts lane/bad/pointer context, whether from idle or as an abort.
  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_bcnt_nxt   = r_bcnt;
    w_bad_nxt    = r_bad;
    w_acc_nxt    = r_acc;
    w_wr_ptr_nxt = r_wr_ptr;
    w_wr_cmt_nxt = r_wr_cmt;
    w_mem_we     = 1'b0;
    w_eof_bad    = 1'b0;
    w_start      = r_in_vld && r_in_sof;
    w_abort      = w_start && (r_state == S_RXD);
    w_accept     = r_in_vld && (w_start || (r_state == S_RXD));
    w_lane       = w_start ? 2'd0 : r_bcnt;
    w_base       = w_start ? r_wr_cmt : r_wr_ptr;
    w_bad_now    = (w_start ? 1'b0 : r_bad) | r_in_err;
    w_full       = (w_base - r_rd_ptr) == FULL_LVL;
    w_wr_word    = w_accept && ((w_lane == 2'd3) || r_in_eof);
    w_wentry.last = r_in_eof;
    case (w_lane)
      2'd0:    begin w_wentry.data = {24'd0, r_in_data};              w_wentry.keep = 4'b0001; end
      2'd1:    begin w_wentry.data = {16'd0, r_in_data, r_acc[7:0]};  w_wentry.keep = 4'b0011; end
      2'd2:    begin w_wentry.data = {8'd0, r_in_data, r_acc[15:0]};  w_wentry.keep = 4'b0111; end
      default: begin w_wentry.data = {r_in_data, r_acc};              w_wentry.keep = 4'b1111; end
    endcase

    if (w_accept) begin
      case (w_lane)
        2'd0:    w_acc_nxt[7:0]   = r_in_data;
        2'd1:    w_acc_nxt[15:8]  = r_in_data;
        2'd2:    w_acc_nxt[23:16] = r_in_data;
        default: ;
      endcase
      if (w_wr_word && w_full) w_bad_now = 1'b1;
      w_mem_we = w_wr_word && !w_bad_now;
      if (r_in_eof) begin
        w_state_nxt = S_IDLE;
        if (w_bad_now) begin
          w_eof_bad    = 1'b1;
          w_wr_ptr_nxt = r_wr_cmt;
        end else begin
          w_wr_ptr_nxt = w_base + {{FIFO_AW{1'b0}}, w_mem_we};
          w_wr_cmt_nxt = w_base + {{FIFO_AW{1'b0}}, w_mem_we};
        end
      end else begin
        w_state_nxt  = S_RXD;
        w_bcnt_nxt   = w_lane + 2'd1;
        w_bad_nxt    = w_bad_now;
        w_wr_ptr_nxt = w_base + {{FIFO_AW{1'b0}}, w_mem_we};
      end
    end

    w_drop_sum = {1'b0, r_drop_cnt} + {16'd0, w_abort} + {16'd0, w_eof_bad};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_bcnt       <= '0;
      r_bad        <= 1'b0;
      r_acc        <= '0;
      r_wr_ptr     <= '0;
      r_wr_cmt     <= '0;
      r_frame_drop <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_bcnt       <= w_bcnt_nxt;
      r_bad        <= w_bad_nxt;
      r_acc        <= w_acc_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_wr_cmt     <= w_wr_cmt_nxt;
      r_frame_drop <= w_abort | w_eof_bad;
      r_drop_cnt   <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  // Read side: RAM read register (prefetch) feeds the output register; pf refills as out drains.
  assign w_out_load = r_pf_vld && (!r_out_vld || bus.axis_tready);
  assign w_rd_en    = (r_wr_cmt != r_rd_ptr) && (!r_pf_vld || w_out_load);

  // NOTE: the storage array and its read register carry no reset; validity is tracked by flags.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_base[FIFO_AW-1:0]] <= w_wentry;
    if (w_rd_en)  r_pf <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr  <= '0;
      r_pf_vld  <= 1'b0;
      r_out_vld <= 1'b0;
      r_out     <= '0;
    end else begin
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_rd_en)         r_pf_vld <= 1'b1;
      else if (w_out_load) r_pf_vld <= 1'b0;
      if (w_out_load) begin
        r_out     <= r_pf;
        r_out_vld <= 1'b1;
      end else if (bus.axis_tready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign bus.axis_tdata  = r_out.data;
  assign bus.axis_tkeep  = r_out.keep;
  assign bus.axis_tlast  = r_out.last;
  assign bus.axis_tvalid = r_out_vld;
  assign frame_drop      = r_frame_drop;
  assign drop_cnt        = r_drop_cnt;

  generate
    if (SIM) begin : g_sim
      a_occupancy : assert property (@(posedge clk) disable iff (!rstn)
        (r_wr_ptr - r_rd_ptr) <= FULL_LVL);
    end
  endgenerate
endmodule

// File: doc/mac_rxbuf.md
Name: mac_rxbuf

Overview:
Receive-side buffer between the byte-wide MAC receiver and the 32-bit AXI-Stream user side. It packs MAC bytes little-endian into 32-bit words with tkeep/tlast, matching the packing mac_txbuf consumes. Frames are stored in an internal word FIFO and released store-and-forward: a frame becomes visible on AXIS only after its last byte arrives intact. Errored, aborted or overflowing frames are discarded entirely and counted.

Parameters:
FIFO_AW, 9, FIFO address width; depth = 2**FIFO_AW words (512 words = 2048 bytes by default)
SIM, 0, simulation-only hooks; no functional effect

Ports:
clk  in  1  single clock for the whole block
rstn  in  1  asynchronous active-low reset
mac_rx_data  in  8  received byte
mac_rx_valid  in  1  byte strobe; qualifies data, sof, eof and err
mac_rx_sof  in  1  first byte of frame, valid with mac_rx_valid
mac_rx_eof  in  1  last byte of frame, valid with mac_rx_valid
mac_rx_err  in  1  frame error (FCS/PHY); may assert on any valid byte of a frame
axis_tready  in  1  sink ready
axis_tdata  out  32  byte0 in [7:0] ... byte3 in [31:24]
axis_tkeep  out  4  contiguous from bit0: 0001/0011/0111/1111
axis_tvalid  out  1  word valid
axis_tlast  out  1  last word of frame
frame_drop  out  1  one-cycle pulse per discarded frame
drop_cnt  out  16  count of discarded frames, saturating at 16'hFFFF

Behaviour:
- Reset (rstn low, asynchronous): all outputs 0; FIFO empty; all pointers 0; state S_IDLE; drop_cnt 0.
- Write pointers: wr_ptr (speculative) and wr_cmt (committed). Read side sees only words below wr_cmt.
- FIFO entry: 32 data + 4 keep + 1 last.
- Full condition: wr_ptr - rd_ptr == 2**FIFO_AW. Pointers are FIFO_AW+1 bits and wrap naturally.
- FSM S_IDLE:
  - A valid byte with sof clears bcnt, clears the bad flag, sets wr_ptr = wr_cmt, and goes to S_RXD.
  - A valid byte without sof is ignored.
- FSM S_RXD: each valid byte is placed at lane bcnt and bcnt increments.
  - A word is written when bcnt == 3 or on eof. tkeep follows the lane count; tlast = eof.
  - A write while full sets the bad flag, and that word is not written.
  - mac_rx_err on any byte sets the bad flag.
  - On eof, clean frame: wr_cmt <= wr_ptr after the final word, then go to S_IDLE.
  - On eof, bad frame: wr_ptr <= wr_cmt, pulse frame_drop, increment drop_cnt, then go to S_IDLE.
- The bad flag does not stop byte sampling. Once set, it suppresses further FIFO writes. The frame is discarded at eof.
- sof arriving in S_RXD before eof aborts the current frame: rollback, frame_drop pulse, drop_cnt increments. That same byte starts a new frame.
- A byte with sof and eof together is a 1-byte frame: tkeep 0001, tlast 1.
- Gaps in mac_rx_valid inside a frame are allowed; packing resumes at the current lane.
- Latency: eof sampled at edge k → word written and committed at k+1 → RAM read at k+2 → axis_tvalid high after edge k+3, provided the output register is empty.
- AXIS output:
  - Registered output stage with one-word prefetch.
  - tdata/tkeep/tlast are held stable while tvalid && !tready.
  - Back-to-back words are delivered with no bubbles when tready stays high.
  - tvalid never asserts for uncommitted data.
- A frame longer than the FIFO depth always overflows and is dropped. Frames already committed are unaffected.
- A simultaneous write and read at full: the read frees space only from the next cycle, so the write is treated as overflow.

Test Plan:
- 64-byte clean frame, bytes 0x00..0x3F, tready=1 → 16 words; first word 0x03020100, tkeep 1111; tlast on word 16; tvalid after edge k+3.
- 5-byte frame 0xA1..0xA5 → two words: 0xA4A3A2A1/1111, then 0x000000A5 (upper bytes don't-care)/0001 with tlast; repeat with 6- and 7-byte frames → final tkeep 0011 and 0111.
- 1-byte frame (sof+eof on the same byte) → single word, tkeep 0001, tlast 1.
- Frame with mac_rx_err on byte 10 → no AXIS output, frame_drop pulse, drop_cnt=1; the following clean frame is delivered intact.
- tready=0 while FIFO_AW=4 (16 words): send a 40-byte frame, then a 100-byte frame → first frame kept; second overflows, is dropped, drop_cnt increments; after tready=1 only the first frame appears.
- sof mid-frame (after 7 bytes), then a complete 8-byte frame → the first frame is dropped (drop_cnt+1); only the 8-byte frame is output. rstn asserted mid-frame → outputs 0 immediately, FIFO empty, drop_cnt 0.
